jtag_seq: RTL and testbench
===========================

JTAG_SEQ -- requirements
Module: jtag_seq

Interface
REQ-001 SHALL have parameter TICK_DELAY, default 50: clock cycles per TCK half-phase minus one; a half-phase is TICK_DELAY+1 cycles.
REQ-002 SHALL have parameter MAX_LEN, default 64: maximum scan length in bits.
REQ-003 SHALL have clock  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high.
REQ-005 SHALL have cmd_valid  input  1, and cmd_ready  output  1: command handshake.
REQ-006 SHALL have cmd_ir  input  1: 1 = IR scan, 0 = DR scan.
REQ-007 SHALL have cmd_len  input  7: scan length in bits.
REQ-008 SHALL have cmd_data  input  MAX_LEN: TDI bits, LSB shifted first.
REQ-009 SHALL have rsp_valid  output  1, and rsp_ready  input  1: response handshake.
REQ-010 SHALL have rsp_data  output  MAX_LEN, and rsp_err  output  1: captured TDO bits and error flag.
REQ-011 SHALL have jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn  output  1 each, and jtag_TDO  input  1.
REQ-012 SHALL have busy  output  1: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL register all outputs; no combinational input-to-output path.
REQ-014 TCK bit period SHALL be 2*(TICK_DELAY+1) clocks: a low phase, then a high phase.
REQ-015 TMS and TDI SHALL update only on the first clock of a low phase.
REQ-016 TDO SHALL be sampled on the clock edge that ends the high phase.
REQ-017 FSM states SHALL be TLR_SEQ, IDLE, PRE, SHIFT, POST and RESP.
REQ-018 TLR_SEQ SHALL issue 5 TCK periods with TMS=1, then 1 period with TMS=0, ending with the TAP in Run-Test/Idle, and then go to IDLE.
REQ-019 In IDLE, cmd_ready SHALL be 1; a command is accepted on cmd_valid&&cmd_ready, and cmd_ready SHALL drop the following cycle.
REQ-020 On accept, cmd_ir, cmd_len and cmd_data SHALL be latched; later input changes SHALL be ignored.
REQ-021 PRE TMS sequence SHALL be 1,0,0 for DR and 1,1,0,0 for IR, reaching Shift-xR.
REQ-022 SHIFT SHALL issue cmd_len periods:
- period i drives TDI=cmd_data[i] and captures TDO into rsp_data[i];
- TMS=0 on every period except the last, which uses TMS=1 (Exit1).
REQ-023 POST SHALL issue TMS sequence 1,0 (Update-xR, then Run-Test/Idle).
REQ-024 Total TCK periods per valid command SHALL be cmd_len+5 for DR and cmd_len+6 for IR.
REQ-025 rsp_data bits at index cmd_len and above SHALL be 0.
REQ-026 If cmd_len==0 or cmd_len>MAX_LEN, the block SHALL go directly to RESP with rsp_err=1, rsp_data=0, and no TCK activity.
REQ-027 In RESP, rsp_valid SHALL be 1 and held stable until rsp_ready; on rsp_valid&&rsp_ready it SHALL return to IDLE the next cycle.
REQ-028 The next command SHALL NOT be accepted while a response is pending.
REQ-029 jtag_TCK SHALL idle at 0, and jtag_TMS at 0, in IDLE and RESP.

Reset
REQ-030 While reset is high, outputs SHALL be: TCK=0, TMS=1, TDI=0, TRSTn=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, busy=1.
REQ-031 On the first cycle after reset falls, TRSTn SHALL go to 1 and the FSM SHALL enter TLR_SEQ.
REQ-032 Reset asserted mid-command SHALL abort the command immediately with no response; the TLR sequence SHALL then be re-run.
REQ-033 Reset SHALL override any simultaneous handshake.

Verification (TICK_DELAY=1, MAX_LEN=64, 4-clock bit period)
REQ-034 Release reset -> 6 TCK pulses with TMS 1,1,1,1,1,0, then cmd_ready=1 exactly 24 clocks after TRSTn rises.
REQ-035 DR scan, len=8, data=0xA5, TDO loopback of TDI delayed one period -> 13 TCK pulses; TDI stream 1,0,1,0,0,1,0,1 during SHIFT; rsp_data=0x4A (bit0 = 0 captured before the first shift), rsp_err=0.
REQ-036 IR scan, len=5, data=0x01, TDO tied 1 -> TMS sequence 1,1,0,0,0,0,0,0,1,1,0; rsp_data=0x1F.
REQ-037 cmd_len=0, then cmd_len=65 -> no TCK edges; rsp_err=1 and rsp_data=0 for both.
REQ-038 rsp_ready held 0 for 20 clocks with cmd_valid=1 -> rsp_valid and rsp_data stable, cmd_ready stays 0; after rsp_ready, the command is accepted 2 clocks later.
REQ-039 Reset pulsed during SHIFT of a len=32 DR scan -> no rsp_valid; the TLR sequence is repeated, then a new command completes normally.

Source files
------------

// File: rtl/jtag_seq.sv
// jtag_seq: JTAG scan sequencer. After reset it walks the TAP to
// Run-Test/Idle, then turns each accepted command into one IR or DR scan.
// The TDO bits captured during the scan come back through a
// valid/ready response channel.
module jtag_seq #(
  parameter int TICK_DELAY = 50,
  parameter int MAX_LEN    = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_ir,
  input  logic [6:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               rsp_err,
  output logic               jtag_TCK,
  output logic               jtag_TMS,
  output logic               jtag_TDI,
  output logic               jtag_TRSTn,
  input  logic               jtag_TDO,
  output logic               busy
);

  typedef enum logic [2:0] {
    TLR_SEQ,
    IDLE,
    PRE,
    SHIFT,
    POST,
    RESP
  } state_t;

  localparam int TW = (TICK_DELAY > 0) ? $clog2(TICK_DELAY + 1) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DELAY);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);

  state_t state_q, state_nxt;

  // Bit-period time base: tick_q counts clocks within a half-phase.
  // high_q marks the high half of the TCK period.
  // idx_q is the period index within the current state.
  logic [TW-1:0] tick_q, tick_nxt;
  logic          high_q, high_nxt;
  logic [6:0]    idx_q, idx_nxt;

  // Command fields latched on accept.
  logic               ir_q;
  logic [6:0]         len_q;
  logic [MAX_LEN-1:0] data_q;

  logic               ir_nxt;
  logic               tck_nxt;
  logic               tms_nxt;
  logic               tdi_nxt;
  logic               cmd_ready_nxt;
  logic               rsp_valid_nxt;
  logic               busy_nxt;
  logic               rsp_err_nxt;
  logic [MAX_LEN-1:0] rsp_data_nxt;

  logic       run;
  logic       phase_end;
  logic       period_end;
  logic       last_period;
  logic       accept;
  logic       bad_len;
  logic       rsp_done;
  logic [6:0] periods;

  // The time base only runs in TCK-driving states. It waits one clock after
  // reset so that the first low phase starts when TRSTn rises.
  assign run = jtag_TRSTn &&
               ((state_q == TLR_SEQ) || (state_q == PRE) ||
                (state_q == SHIFT)   || (state_q == POST));
  assign phase_end  = (tick_q == TICK_MAX);
  assign period_end = run && high_q && phase_end;

  assign periods = (state_q == TLR_SEQ) ? 7'd6 :
                   (state_q == PRE)     ? (ir_q ? 7'd4 : 7'd3) :
                   (state_q == SHIFT)   ? len_q :
                                          7'd2;
  assign last_period = (idx_q == periods - 7'd1);

  assign accept   = cmd_valid && cmd_ready;
  assign bad_len  = (cmd_len == 7'd0) || (cmd_len > MAX_LEN_C);
  assign rsp_done = rsp_valid && rsp_ready;
  assign ir_nxt   = accept ? cmd_ir : ir_q;

  // State register: FSM state, time base, latched command and every output
  // flop. Reset overrides any handshake in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= TLR_SEQ;
      tick_q     <= '0;
      high_q     <= 1'b0;
      idx_q      <= '0;
      ir_q       <= 1'b0;
      len_q      <= '0;
      data_q     <= '0;
      jtag_TCK   <= 1'b0;
      jtag_TMS   <= 1'b1;
      jtag_TDI   <= 1'b0;
      jtag_TRSTn <= 1'b0;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_data   <= '0;
      busy       <= 1'b1;
    end else begin
      state_q    <= state_nxt;
      tick_q     <= tick_nxt;
      high_q     <= high_nxt;
      idx_q      <= idx_nxt;
      if (accept) begin
        ir_q   <= cmd_ir;
        len_q  <= cmd_len;
        data_q <= cmd_data;
      end
      jtag_TCK   <= tck_nxt;
      jtag_TMS   <= tms_nxt;
      jtag_TDI   <= tdi_nxt;
      jtag_TRSTn <= 1'b1;
      cmd_ready  <= cmd_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_err    <= rsp_err_nxt;
      rsp_data   <= rsp_data_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next state: advance the half-phase counter. On the last period of a
  // sequence, step to the next state. Commands and responses are
  // handshaked in IDLE and RESP.
  always_comb begin
    state_nxt = state_q;
    tick_nxt  = tick_q;
    high_nxt  = high_q;
    idx_nxt   = idx_q;
    if (run) begin
      if (phase_end) begin
        tick_nxt = '0;
        high_nxt = ~high_q;
      end else begin
        tick_nxt = tick_q + 1'b1;
      end
      if (period_end) begin
        if (last_period) begin
          idx_nxt = '0;
          case (state_q)
            TLR_SEQ: state_nxt = IDLE;
            PRE:     state_nxt = SHIFT;
            SHIFT:   state_nxt = POST;
            POST:    state_nxt = RESP;
            default: state_nxt = state_q;
          endcase
        end else begin
          idx_nxt = idx_q + 7'd1;
        end
      end
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_nxt = bad_len ? RESP : PRE;
          tick_nxt  = '0;
          high_nxt  = 1'b0;
          idx_nxt   = '0;
        end
      end
      RESP: begin
        if (rsp_done) begin
          state_nxt = IDLE;
        end
      end
      default: ;
    endcase
  end

  // Output decode from the upcoming state and period. TMS and TDI depend
  // only on the period index, so they change only when a new low phase
  // begins. TDO is captured on the edge that ends each SHIFT high phase.
  always_comb begin
    tck_nxt       = high_nxt;
    tms_nxt       = 1'b0;
    tdi_nxt       = 1'b0;
    cmd_ready_nxt = (state_nxt == IDLE);
    rsp_valid_nxt = (state_nxt == RESP);
    busy_nxt      = (state_nxt != IDLE);
    rsp_err_nxt   = rsp_err;
    rsp_data_nxt  = rsp_data;
    case (state_nxt)
      TLR_SEQ: tms_nxt = (idx_nxt < 7'd5);
      PRE:     tms_nxt = (idx_nxt == 7'd0) || (ir_nxt && (idx_nxt == 7'd1));
      SHIFT: begin
        tms_nxt = (idx_nxt == len_q - 7'd1);
        tdi_nxt = data_q[idx_nxt[IW-1:0]];
      end
      POST:    tms_nxt = (idx_nxt == 7'd0);
      default: ;
    endcase
    if (accept) begin
      rsp_err_nxt  = bad_len;
      rsp_data_nxt = '0;
    end else if (period_end && (state_q == SHIFT)) begin
      rsp_data_nxt[idx_q[IW-1:0]] = jtag_TDO;
    end
  end

endmodule

// File: tb/tb_jtag_seq.sv
// tb_jtag_seq: randomized self-checking bench for jtag_seq. A TCK monitor
// records TMS/TDI per period and plays a planned TDO stream. Results are
// compared with a behavioural scan model.
module tb_jtag_seq;

  localparam int TD       = 1;
  localparam int ML       = 64;
  localparam int BIT_CLKS = 2 * (TD + 1);

  logic          clock;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_ir;
  logic [6:0]    cmd_len;
  logic [ML-1:0] cmd_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [ML-1:0] rsp_data;
  logic          rsp_err;
  logic          jtag_TCK;
  logic          jtag_TMS;
  logic          jtag_TDI;
  logic          jtag_TRSTn;
  logic          jtag_TDO;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Monitor control, written by the main sequence only.
  int          mon_req = 0;
  int          mon_pre = 0;
  int          mon_len = 0;
  logic [63:0] mon_plan = '0;

  // Monitor observations, written by the monitor only.
  int           mon_seen = 0;
  int           mon_p = 0;
  logic [127:0] mon_tms = '0;
  logic [63:0]  mon_tdi = '0;

  jtag_seq #(
    .TICK_DELAY(TD),
    .MAX_LEN   (ML)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .jtag_TCK  (jtag_TCK),
    .jtag_TMS  (jtag_TMS),
    .jtag_TDI  (jtag_TDI),
    .jtag_TRSTn(jtag_TRSTn),
    .jtag_TDO  (jtag_TDO),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case anything wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // TCK monitor: on each TCK rise, record TMS/TDI and present the planned
  // TDO bit for that period.
  initial begin
    logic tck_last;
    tck_last = 1'b0;
    jtag_TDO = 1'b0;
    forever begin
      @(negedge clock);
      if (mon_seen != mon_req) begin
        mon_seen = mon_req;
        mon_p    = 0;
        mon_tms  = '0;
        mon_tdi  = '0;
      end
      if (jtag_TCK && !tck_last) begin
        if (mon_p < 128) mon_tms[mon_p] = jtag_TMS;
        if (mon_p >= mon_pre && mon_p < mon_pre + mon_len) begin
          mon_tdi[mon_p - mon_pre] = jtag_TDI;
          jtag_TDO = mon_plan[mon_p - mon_pre];
        end else begin
          jtag_TDO = 1'($urandom_range(0, 1));
        end
        mon_p++;
      end
      tck_last = jtag_TCK;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic armMonitor(input int pre, input int len, input logic [63:0] plan);
    mon_pre  = pre;
    mon_len  = len;
    mon_plan = plan;
    mon_req++;
  endtask

  // Behavioural scan model: the TMS path through the TAP for one scan.
  function automatic void modelScan(input logic ir, input int len,
                                    output logic [127:0] tms, output int pulses);
    logic q[$];
    q.push_back(1'b1);
    if (ir) q.push_back(1'b1);
    q.push_back(1'b0);
    q.push_back(1'b0);
    for (int i = 0; i < len; i++) q.push_back(i == len - 1);
    q.push_back(1'b1);
    q.push_back(1'b0);
    tms = '0;
    foreach (q[i]) tms[i] = q[i];
    pulses = q.size();
  endfunction

  function automatic logic [63:0] lenMask(input int len);
    if (len >= 64) return '1;
    return (64'd1 << len) - 64'd1;
  endfunction

  // Run the TAP reset walk.
  // Entered with reset high and at least one clock edge applied.
  task automatic runTlr();
    int n;
    logic saw_rsp;
    checkOutput("reset_outs",
                128'({jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, cmd_ready, rsp_valid, rsp_err, busy}),
                128'(8'b0100_0001));
    checkOutput("reset_rsp_data", 128'(rsp_data), 128'(0));
    armMonitor(0, 0, 64'd0);
    reset = 1'b0;
    tick();
    checkOutput("trstn_rise", 128'({jtag_TRSTn, cmd_ready, busy}), 128'(3'b101));
    n = 0;
    saw_rsp = 1'b0;
    while (!cmd_ready && n < 200) begin
      tick();
      n++;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    checkOutput("tlr_ready_clks", 128'(n), 128'(24));
    checkOutput("tlr_pulses", 128'(mon_p), 128'(6));
    checkOutput("tlr_tms", mon_tms, 128'(6'b01_1111));
    checkOutput("tlr_no_rsp", 128'(saw_rsp), 128'(0));
  endtask

  // One command. mode selects TDO: 0 = TDI looped back one period late,
  // 1 = tied high, other = random.
  task automatic applyStimulus(input logic ir, input logic [6:0] len, input logic [63:0] data,
                               input int mode, input int hold);
    int           ilen;
    int           pre;
    bit           bad;
    logic [63:0]  plan;
    logic [127:0] exp_tms;
    int           exp_pulses;
    logic [63:0]  exp_rsp;
    logic [63:0]  exp_tdi;
    int           waited;
    logic [63:0]  snap_data;
    logic         snap_err;
    bit           stable;

    ilen = int'(len);
    pre  = ir ? 4 : 3;
    bad  = (ilen == 0) || (ilen > ML);
    for (int i = 0; i < 64; i++) begin
      if (mode == 0)      plan[i] = (i == 0) ? 1'b0 : data[i-1];
      else if (mode == 1) plan[i] = 1'b1;
      else                plan[i] = 1'($urandom_range(0, 1));
    end
    if (bad) begin
      exp_tms    = '0;
      exp_pulses = 0;
      exp_rsp    = '0;
      exp_tdi    = '0;
    end else begin
      modelScan(ir, ilen, exp_tms, exp_pulses);
      exp_rsp = plan & lenMask(ilen);
      exp_tdi = data & lenMask(ilen);
    end

    waited = 0;
    while (!cmd_ready && waited < 400) begin
      tick();
      waited++;
    end
    if (!cmd_ready) begin
      checkOutput("ready_timeout", 128'(cmd_ready), 128'(1));
      return;
    end
    armMonitor(pre, bad ? 0 : ilen, plan);
    cmd_valid = 1'b1;
    cmd_ir    = ir;
    cmd_len   = len;
    cmd_data  = data;
    tick();
    cmd_valid = 1'b0;
    cmd_ir    = 1'($urandom);
    cmd_len   = 7'($urandom);
    cmd_data  = {$urandom, $urandom};
    checkOutput("accept", 128'({cmd_ready, busy}), 128'(2'b01));

    waited = 0;
    while (!rsp_valid && waited < (ilen + 8) * BIT_CLKS + 20) begin
      tick();
      waited++;
    end
    checkOutput("rsp_valid", 128'(rsp_valid), 128'(1));
    if (!rsp_valid) return;

    snap_data = rsp_data;
    snap_err  = rsp_err;
    checkOutput("rsp_pins_idle", 128'({jtag_TCK, jtag_TMS, cmd_ready}), 128'(3'b000));
    stable    = 1'b1;
    cmd_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!rsp_valid || rsp_data !== snap_data || rsp_err !== snap_err || cmd_ready)
        stable = 1'b0;
    end
    cmd_valid = 1'b0;
    if (hold > 0) checkOutput("hold_stable", 128'(stable), 128'(1));

    checkOutput("tck_pulses", 128'(mon_p), 128'(exp_pulses));
    checkOutput("tms_seq", mon_tms, exp_tms);
    checkOutput("tdi_seq", 128'(mon_tdi), 128'(exp_tdi));
    checkOutput("rsp_data", 128'(snap_data), 128'(exp_rsp));
    checkOutput("rsp_err", 128'(snap_err), 128'(bad));

    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("release", 128'({rsp_valid, cmd_ready, busy, jtag_TCK, jtag_TMS}), 128'(5'b01000));
  endtask

  // Main sequence: reset walk, directed cases, random commands, then a
  // reset in the middle of a scan.
  initial begin
    int n;
    logic [63:0] plan;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_ir    = 1'b0;
    cmd_len   = '0;
    cmd_data  = '0;
    repeat (3) tick();
    runTlr();

    applyStimulus(1'b0, 7'd8, 64'hA5, 0, 0);
    applyStimulus(1'b1, 7'd5, 64'h01, 1, 0);
    applyStimulus(1'b0, 7'd0, {$urandom, $urandom}, 2, 3);
    applyStimulus(1'b1, 7'd65, {$urandom, $urandom}, 2, 3);
    applyStimulus(1'b0, 7'd16, {$urandom, $urandom}, 2, 20);
    applyStimulus(1'b0, 7'd1, {$urandom, $urandom}, 2, 1);
    applyStimulus(1'b1, 7'd64, {$urandom, $urandom}, 0, 2);

    for (int k = 0; k < 16; k++) begin
      logic [6:0] len;
      if ($urandom_range(0, 7) == 0)
        len = ($urandom_range(0, 1) == 0) ? 7'd0 : 7'($urandom_range(65, 127));
      else
        len = 7'($urandom_range(1, 64));
      applyStimulus(1'($urandom), len, {$urandom, $urandom},
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 4)));
    end

    n = 0;
    while (!cmd_ready && n < 400) begin
      tick();
      n++;
    end
    for (int i = 0; i < 64; i++) plan[i] = 1'($urandom_range(0, 1));
    armMonitor(3, 32, plan);
    cmd_valid = 1'b1;
    cmd_ir    = 1'b0;
    cmd_len   = 7'd32;
    cmd_data  = {$urandom, $urandom};
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (mon_p < 13 && n < 300) begin
      tick();
      n++;
    end
    checkOutput("shift_reached", 128'(mon_p >= 13), 128'(1));
    reset = 1'b1;
    tick();
    tick();
    runTlr();
    applyStimulus(1'b0, 7'd12, {$urandom, $urandom}, 2, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
